// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator with registered syncs, DE, coordinates and a look-ahead fetch stream
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int HSYNC_POL  = 0,
    parameter int VSYNC_POL  = 0,
    parameter int FETCH_LEAD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic       fetch_valid,
    output logic [9:0] fetch_x,
    output logic [9:0] fetch_y
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_TOT_W   = 11'(H_TOTAL);
    localparam logic [10:0] H_ACT_W   = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_W   = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG_W  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_W  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG_W  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END_W  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] LEAD_W    = 11'(FETCH_LEAD);
    localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
    localparam logic        HS_ON     = 1'(HSYNC_POL);
    localparam logic        VS_ON     = 1'(VSYNC_POL);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (FETCH_LEAD < 1 || FETCH_LEAD > H_FP + H_SYNC + H_BP) begin : g_lead_check
        $error("vga_timing_gen: FETCH_LEAD must lie in 1..H_FP+H_SYNC+H_BP");
    end

    logic       running_q, running_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       fetch_valid_q, fetch_valid_d;
    logic [9:0] fetch_x_q, fetch_x_d;
    logic [9:0] fetch_y_q, fetch_y_d;

    logic [10:0] fetch_sum;
    logic [9:0]  ahead_x;
    logic [9:0]  ahead_y;

    // Outputs are decoded from the next position so that, once registered,
    // every output describes the same (x, y) that the position flops show.
    always_comb begin
        running_d = running_q;
        x_d       = x_q;
        y_d       = y_q;
        if (!enable) begin
            running_d = 1'b0;
            x_d       = '0;
            y_d       = '0;
        end else if (!running_q) begin
            running_d = 1'b1;
            x_d       = '0;
            y_d       = '0;
        end else if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end else begin
            x_d = x_q + 10'd1;
        end

        // FETCH_LEAD never exceeds the blanking width, so at most one line wrap.
        fetch_sum = {1'b0, x_d} + LEAD_W;
        if (fetch_sum >= H_TOT_W) begin
            ahead_x = 10'(fetch_sum - H_TOT_W);
            ahead_y = (y_d == V_LAST) ? 10'd0 : y_d + 10'd1;
        end else begin
            ahead_x = fetch_sum[9:0];
            ahead_y = y_d;
        end

        hsync_d       = ~HS_ON;
        vsync_d       = ~VS_ON;
        de_d          = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_x_d     = '0;
        fetch_y_d     = '0;
        if (running_d) begin
            de_d          = ({1'b0, x_d} < H_ACT_W) && ({1'b0, y_d} < V_ACT_W);
            hsync_d       = (({1'b0, x_d} >= HS_BEG_W) && ({1'b0, x_d} < HS_END_W)) ? HS_ON : ~HS_ON;
            vsync_d       = (({1'b0, y_d} >= VS_BEG_W) && ({1'b0, y_d} < VS_END_W)) ? VS_ON : ~VS_ON;
            line_start_d  = (x_d == 10'd0);
            frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
            fetch_valid_d = ({1'b0, ahead_x} < H_ACT_W) && ({1'b0, ahead_y} < V_ACT_W);
            fetch_x_d     = fetch_valid_d ? ahead_x : fetch_x_q;
            fetch_y_d     = fetch_valid_d ? ahead_y : fetch_y_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q     <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HS_ON;
            vsync_q       <= ~VS_ON;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_x_q     <= '0;
            fetch_y_q     <= '0;
        end else begin
            running_q     <= running_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_x_q     <= fetch_x_d;
            fetch_y_q     <= fetch_y_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_x     = fetch_x_q;
    assign fetch_y     = fetch_y_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Video timing generator clocked by the PLL's 25.125 MHz pixel clock; nominal 640x480@60 timing, 800x525 total.
- Produces registered hsync, vsync and display-enable, plus the current pixel coordinates.
- Issues a look-ahead fetch stream so the frame-buffer/character path can return pixel data exactly when DE is high.
- Sits between the PLL (clock plus lock-qualified enable) and the video output/pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync (0 = active-low)
- FETCH_LEAD, 2, cycles fetch_valid leads DE; legal range 1..H_FP+H_SYNC+H_BP

Ports:
- clk  in  1  pixel clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request, normally the PLL lock; sampled synchronously
- hsync  out  1  horizontal sync at HSYNC_POL
- vsync  out  1  vertical sync at VSYNC_POL
- de  out  1  display enable (position is inside the visible area)
- x  out  10  current horizontal position, 0..H_TOTAL-1
- y  out  10  current vertical position, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse at x==0
- frame_start  out  1  one-cycle pulse at x==0, y==0
- fetch_valid  out  1  fetch request for pixel (fetch_x, fetch_y)
- fetch_x  out  10  pixel column to fetch, 0..H_ACTIVE-1
- fetch_y  out  10  pixel row to fetch, 0..V_ACTIVE-1

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
- Every output is a flop output; no combinational path from any input to any output.
- All outputs are mutually coherent: each describes the position (x, y) shown in the same cycle.
- Async reset:
  - internal running=0, position=(0,0)
  - hsync=!HSYNC_POL, vsync=!VSYNC_POL
  - de, line_start, frame_start, fetch_valid = 0
  - x, y, fetch_x, fetch_y = 0
- States:
  - IDLE (running=0): position held at (0,0); outputs at their reset values.
  - RUN (running=1).
- IDLE to RUN: first edge with enable=1. Position stays (0,0); outputs now decode (0,0), so frame_start=1, line_start=1, de=1.
- RUN, each edge with enable=1:
  - x increments.
  - At x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 with x wrapping, y wraps to 0.
- RUN to IDLE: any edge with enable=0. Synchronous return to the reset values, even mid-line or mid-frame. The next enable restarts at (0,0) with frame_start.
- Decodes, valid in RUN only:
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751), on every line including vertical blanking.
  - vsync active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491). Edges align with x==0.
- Fetch look-ahead:
  - fetch_valid=1 exactly when the position FETCH_LEAD cycles later (in raster order, with wrap) has de=1.
  - fetch_x/fetch_y name that future pixel.
  - Consequence: with FETCH_LEAD=2, pixels 0 and 1 of line y are requested at x=798, 799 of line y-1.
  - Pixels 0 and 1 of line 0 are requested at x=798, 799 of line 524.
  - No fetch is issued for line V_ACTIVE; fetches stop after pixel (639,479).
  - After IDLE to RUN, fetches for pixels 0..FETCH_LEAD-1 of line 0 are never issued (lead unavailable). Downstream tolerates this first-frame artefact.
  - fetch_x/fetch_y hold their last value when fetch_valid=0.
- Widths: all counters are 10 bits. Parameters must give H_TOTAL, V_TOTAL <= 1024; this is checked at elaboration.

Test Plan:
- Reset, then enable=1 at cycle 10 -> next cycle x=0, y=0, de=1, frame_start=1, hsync=vsync=1. x=639,de=1 then x=640,de=0 on following edges.
- Run one line -> hsync low for exactly 96 cycles, x=656..751. line_start period is 800 cycles; x wraps 799 to 0 with y incrementing.
- Run two full frames -> frame_start period is 420000 cycles. vsync low for 1600 cycles, y=490..491, asserted and released at x==0. de high for 640x480 cycles per frame.
- Fetch, FETCH_LEAD=2:
  - At y=0, x=798 -> fetch_valid=1, fetch=(0,1).
  - At x=638 -> fetch=(640?) is not issued; the last fetch of the line is (639,y) at x=637.
  - At y=479, x=798 -> fetch_valid=0.
  - At y=524, x=798 -> fetch=(0,0).
- enable dropped at y=200, x=300 -> next cycle all outputs at reset values. Re-enable -> restart at (0,0) with frame_start=1.
- Async reset asserted mid-hsync (x=700) -> outputs idle immediately, without waiting for a clock edge. After release, remain idle until an enable edge.
